// File: rtl/button_event_if.sv
// Button-channel inputs and the serialised event handshake of button_event_arbiter.
// The arbiter uses the master modport; the button front ends and the consumer use slave.
interface button_event_if #(
  parameter int unsigned N_BTN = 4,
  parameter int unsigned IDW   = $clog2(N_BTN)
);
  logic [N_BTN-1:0] pb_pulse;
  logic [N_BTN-1:0] pb_level;
  logic             evt_ready;
  logic             clr_ovf;
  logic             evt_valid;
  logic [IDW-1:0]   evt_id;
  logic [N_BTN-1:0] pending;
  logic             overflow;

  modport master (
    input  pb_pulse, pb_level, evt_ready, clr_ovf,
    output evt_valid, evt_id, pending, overflow
  );

  modport slave (
    output pb_pulse, pb_level, evt_ready, clr_ovf,
    input  evt_valid, evt_id, pending, overflow
  );
endinterface

// File: rtl/button_event_arbiter.sv
// Round-robin serialiser of button press pulses into a valid/ready event stream.
// Define BTN_AUTOREPEAT_EN to add per-button hold-to-repeat pulse generation.
module button_event_arbiter #(
  parameter int unsigned N_BTN         = 4,
  parameter int unsigned IDW           = $clog2(N_BTN),
  parameter int unsigned HOLD_CYCLES   = 50_000_000,
  parameter int unsigned REPEAT_CYCLES = 10_000_000
) (
  input logic            clk,
  input logic            rst,
  button_event_if.master bus_io
);
  typedef enum logic [0:0] {StIdle, StOffer} state_e;

  state_e           state_q, state_d;
  logic             evt_valid_q, evt_valid_d;
  logic [IDW-1:0]   evt_id_q, evt_id_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   winner;
  logic [N_BTN-1:0] pending_q, pending_d;
  logic [N_BTN-1:0] pulse_eff, clr_vec, rep_pulse;
  logic             overflow_q, overflow_d;
  logic             accept, lost;

`ifdef BTN_AUTOREPEAT_EN
  logic [31:0]      cnt_q [N_BTN];
  logic [31:0]      cnt_d [N_BTN];
  logic [N_BTN-1:0] rep_q, rep_d;

  // rep_q selects the repeat period once the first hold period has elapsed
  always_comb begin
    cnt_d     = cnt_q;
    rep_d     = rep_q;
    rep_pulse = '0;
    for (int i = 0; i < int'(N_BTN); i++) begin
      if (!bus_io.pb_level[i]) begin
        cnt_d[i] = '0;
        rep_d[i] = 1'b0;
      end else if (cnt_q[i] == (rep_q[i] ? REPEAT_CYCLES - 1 : HOLD_CYCLES - 1)) begin
        rep_pulse[i] = 1'b1;
        cnt_d[i]     = '0;
        rep_d[i]     = 1'b1;
      end else begin
        cnt_d[i] = cnt_q[i] + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '{default: '0};
      rep_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      rep_q <= rep_d;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{bus_io.pb_level, HOLD_CYCLES, REPEAT_CYCLES};
  assign rep_pulse  = '0;
`endif

  assign pulse_eff = bus_io.pb_pulse | rep_pulse;
  assign accept    = (state_q == StOffer) && bus_io.evt_ready;

  always_comb begin
    clr_vec = '0;
    if (accept) clr_vec[evt_id_q] = 1'b1;
  end

  // A re-press of the bit being accepted this cycle is kept, not lost
  assign pending_d  = (pending_q & ~clr_vec) | pulse_eff;
  assign lost       = |(pulse_eff & pending_q & ~clr_vec);
  assign overflow_d = lost ? 1'b1 : (bus_io.clr_ovf ? 1'b0 : overflow_q);

  // Search starts just after the last granted index and wraps around
  always_comb begin
    int   idx;
    logic found;
    idx    = 0;
    found  = 1'b0;
    winner = ptr_q;
    for (int off = 1; off <= int'(N_BTN); off++) begin
      idx = int'(ptr_q) + off;
      if (idx >= int'(N_BTN)) idx = idx - int'(N_BTN);
      if (!found && pending_q[idx]) begin
        found  = 1'b1;
        winner = IDW'(idx);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    evt_valid_d = evt_valid_q;
    evt_id_d    = evt_id_q;
    ptr_d       = ptr_q;
    unique case (state_q)
      StIdle: begin
        if (|pending_q) begin
          state_d     = StOffer;
          evt_valid_d = 1'b1;
          evt_id_d    = winner;
        end
      end
      StOffer: begin
        if (bus_io.evt_ready) begin
          state_d     = StIdle;
          evt_valid_d = 1'b0;
          ptr_d       = evt_id_q;
        end
      end
      default: begin
        state_d     = StIdle;
        evt_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      evt_valid_q <= 1'b0;
      evt_id_q    <= '0;
      ptr_q       <= IDW'(N_BTN - 1);
      pending_q   <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      evt_valid_q <= evt_valid_d;
      evt_id_q    <= evt_id_d;
      ptr_q       <= ptr_d;
      pending_q   <= pending_d;
      overflow_q  <= overflow_d;
    end
  end

  assign bus_io.evt_valid = evt_valid_q;
  assign bus_io.evt_id    = evt_id_q;
  assign bus_io.pending   = pending_q;
  assign bus_io.overflow  = overflow_q;
endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed bench for button_event_arbiter: vector table plus fairness and auto-repeat sequences.
module tb_button_event_arbiter;
  localparam int unsigned NB = 4;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp  = 0;
  int   n_fail = 0;

  button_event_if #(.N_BTN(NB)) bus ();

  button_event_arbiter #(
    .N_BTN        (NB),
    .HOLD_CYCLES  (8),
    .REPEAT_CYCLES(4)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus_io(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] pulse;
    logic       rdy;
    logic       clr;
    logic       valid;
    logic [1:0] id;
    logic [3:0] pend;
    logic       ovf;
  } vec_t;

  vec_t vecs [23];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic v, input logic [1:0] id,
                            input logic [3:0] pend, input logic ovf);
    check({tag, " valid"}, 32'(bus.evt_valid), 32'(v));
    check({tag, " id"}, 32'(bus.evt_id), 32'(id));
    check({tag, " pending"}, 32'(bus.pending), 32'(pend));
    check({tag, " overflow"}, 32'(bus.overflow), 32'(ovf));
  endtask

  task automatic drive(input logic [3:0] pulse, input logic rdy, input logic clr);
    bus.pb_pulse  = pulse;
    bus.evt_ready = rdy;
    bus.clr_ovf   = clr;
  endtask

  initial begin
    int ev_a;
    int ev_b;

    // {rst, pulse, rdy, clr, exp valid, exp id, exp pending, exp overflow}
    vecs[0]  = '{1'b0, 4'b0100, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0100, 1'b0};
    vecs[1]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd2, 4'b0100, 1'b0};
    vecs[2]  = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd2, 4'b0000, 1'b0};
    vecs[3]  = '{1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0};
    vecs[4]  = '{1'b0, 4'b1111, 1'b1, 1'b0, 1'b0, 2'd0, 4'b1111, 1'b0};
    vecs[5]  = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd0, 4'b1111, 1'b0};
    vecs[6]  = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'b1110, 1'b0};
    vecs[7]  = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd1, 4'b1110, 1'b0};
    vecs[8]  = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd1, 4'b1100, 1'b0};
    vecs[9]  = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd2, 4'b1100, 1'b0};
    vecs[10] = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd2, 4'b1000, 1'b0};
    vecs[11] = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd3, 4'b1000, 1'b0};
    vecs[12] = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd3, 4'b0000, 1'b0};
    vecs[13] = '{1'b0, 4'b0001, 1'b0, 1'b0, 1'b0, 2'd3, 4'b0001, 1'b0};
    vecs[14] = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0001, 1'b0};
    vecs[15] = '{1'b0, 4'b0001, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0001, 1'b1};
    vecs[16] = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0001, 1'b1};
    vecs[17] = '{1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 2'd0, 4'b0001, 1'b0};
    vecs[18] = '{1'b0, 4'b0001, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0001, 1'b0};
    vecs[19] = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0001, 1'b0};
    vecs[20] = '{1'b0, 4'b0001, 1'b0, 1'b1, 1'b1, 2'd0, 4'b0001, 1'b1};
    vecs[21] = '{1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0};
    vecs[22] = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0};

    rst          = 1'b1;
    bus.pb_level = '0;
    drive(4'b0000, 1'b0, 1'b0);
    tick();
    tick();
    check_outs("reset", 1'b0, 2'd0, 4'b0000, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 23; i++) begin
      rst = vecs[i].rst;
      drive(vecs[i].pulse, vecs[i].rdy, vecs[i].clr);
      tick();
      check_outs($sformatf("vec%0d", i), vecs[i].valid, vecs[i].id, vecs[i].pend, vecs[i].ovf);
    end
    rst = 1'b0;
    drive(4'b0000, 1'b0, 1'b0);

    // Fairness: grant button 1 so the pointer sits at 1, then 1 and 3 compete
    drive(4'b0010, 1'b0, 1'b0);
    tick();
    drive(4'b0000, 1'b0, 1'b0);
    tick();
    check("fair first id1", 32'(bus.evt_id), 32'd1);
    drive(4'b0000, 1'b1, 1'b0);
    tick();
    drive(4'b1010, 1'b0, 1'b0);
    tick();
    drive(4'b0000, 1'b0, 1'b0);
    tick();
    check("fair valid", 32'(bus.evt_valid), 32'd1);
    check("fair id3 before id1", 32'(bus.evt_id), 32'd3);
    drive(4'b0000, 1'b1, 1'b0);
    tick();
    drive(4'b0000, 1'b0, 1'b0);
    tick();
    check("fair then id1", 32'(bus.evt_id), 32'd1);
    check("fair pending", 32'(bus.pending), 32'b0010);

`ifdef BTN_AUTOREPEAT_EN
    rst = 1'b1;
    tick();
    rst  = 1'b0;
    ev_a = 0;
    ev_b = 0;
    bus.pb_level = 4'b0010;
    drive(4'b0010, 1'b1, 1'b0);
    for (int c = 1; c <= 45; c++) begin
      tick();
      if (c == 1) bus.pb_pulse = 4'b0000;
      if (c == 19) bus.pb_level = 4'b0000;
      if (bus.evt_valid) begin
        check($sformatf("repeat id c%0d", c), 32'(bus.evt_id), 32'd1);
        if (c <= 22) ev_a++;
        else ev_b++;
      end
    end
    check("repeat events while held", 32'(ev_a), 32'd4);
    check("repeat events after release", 32'(ev_b), 32'd0);
`else
    ev_a = 0;
    ev_b = 0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
